// File: rtl/ex_iter_pkg.sv
// Shared RV32I execute-stage constants: bus widths, ALU class codes, opcode and funct encodings,
// plus the one-bit shift step used by the iterative shifter.
package ex_iter_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;
  localparam int AluselBus  = 3;
  localparam int OpcodeBus  = 7;
  localparam int Func3Bus   = 3;
  localparam int Func7Bus   = 7;

  localparam logic RstEnable    = 1'b1;
  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [AluselBus-1:0] ALU_NOP = 3'b000;
  localparam logic [AluselBus-1:0] ALU_ARI = 3'b001;
  localparam logic [AluselBus-1:0] ALU_LOG = 3'b010;
  localparam logic [AluselBus-1:0] ALU_SHI = 3'b011;

  localparam logic [OpcodeBus-1:0] OP_OP     = 7'b0110011;
  localparam logic [OpcodeBus-1:0] OP_OP_IMM = 7'b0010011;

  localparam logic [Func3Bus-1:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [Func3Bus-1:0] FUNCT3_SLL     = 3'b001;
  localparam logic [Func3Bus-1:0] FUNCT3_SLT     = 3'b010;
  localparam logic [Func3Bus-1:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [Func3Bus-1:0] FUNCT3_XOR     = 3'b100;
  localparam logic [Func3Bus-1:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [Func3Bus-1:0] FUNCT3_OR      = 3'b110;
  localparam logic [Func3Bus-1:0] FUNCT3_AND     = 3'b111;

  localparam logic [Func7Bus-1:0] FUNCT7_ZERO   = 7'b0000000;
  localparam logic [Func7Bus-1:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [Func7Bus-1:0] EXE_FUNC7_NOP = 7'b0000000;

  // dir=0 shifts left with zero fill; dir=1 shifts right, filling with the sign bit when arith=1.
  function automatic logic [RegBus-1:0] shift_one(input logic [RegBus-1:0] v,
                                                  input logic dir, input logic arith);
    if (dir) return {arith & v[RegBus-1], v[RegBus-1:1]};
    else     return {v[RegBus-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/ex_iter_if.sv
// Decode-to-execute bus: decoded fields in, stall request and forwarding/EX-MEM results out.
// Handshake: stallreq_o is the inverse of ready. An instruction is consumed on a rising edge where
// stallreq_o=0 and stall_i=0; while stallreq_o=1 decode must keep presenting the same fields.
interface ex_iter_if;
  import ex_iter_pkg::*;

  logic [AluselBus-1:0]  alusel_i;
  logic [OpcodeBus-1:0]  opcode_i;
  logic [Func3Bus-1:0]   func3_i;
  logic [Func7Bus-1:0]   func7_i;
  logic [RegBus-1:0]     reg1_i;
  logic [RegBus-1:0]     reg2_i;
  logic [RegAddrBus-1:0] wd_i;
  logic                  wreg_i;
  logic                  stall_i;

  logic                  stallreq_o;
  logic                  ex_wreg_o;
  logic [RegAddrBus-1:0] ex_wd_o;
  logic [RegBus-1:0]     ex_wdata_o;
  logic                  wreg_o;
  logic [RegAddrBus-1:0] wd_o;
  logic [RegBus-1:0]     wdata_o;
  logic                  dbg_shift_state_o;

  modport master (
    output alusel_i, opcode_i, func3_i, func7_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i,
    input  stallreq_o, ex_wreg_o, ex_wd_o, ex_wdata_o, wreg_o, wd_o, wdata_o, dbg_shift_state_o
  );

  modport slave (
    input  alusel_i, opcode_i, func3_i, func7_i, reg1_i, reg2_i, wd_i, wreg_i, stall_i,
    output stallreq_o, ex_wreg_o, ex_wd_o, ex_wdata_o, wreg_o, wd_o, wdata_o, dbg_shift_state_o
  );

endinterface

// File: rtl/ex_iter_shifter.sv
// ex_shifter: 1-bit-per-cycle shifter (IDLE/SHIFT FSM) or, with EX_BARREL_SHIFT_EN defined,
// a single-cycle barrel shifter with busy tied low. state_o exposes the FSM state.
module ex_shifter
  import ex_iter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              start_i,
  input  logic              dir_i,
  input  logic              arith_i,
  input  logic [4:0]        shamt_i,
  input  logic [RegBus-1:0] operand_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [RegBus-1:0] result_o,
  output logic              state_o
);

`ifdef EX_BARREL_SHIFT_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, stall_i};

  always_comb begin
    result_o = operand_i;
    if (dir_i) begin
      if (arith_i) result_o = $signed(operand_i) >>> shamt_i;
      else         result_o = operand_i >> shamt_i;
    end else begin
      result_o = operand_i << shamt_i;
    end
  end

  assign busy_o  = 1'b0;
  assign done_o  = start_i;
  assign state_o = 1'b0;

`else

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {IDLE = ST_IDLE, SHIFT = ST_SHIFT} state_t;

  state_t            state_q, state_d;
  logic [RegBus-1:0] acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              dir_q, dir_d;
  logic              arith_q, arith_d;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    arith_d  = arith_q;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    result_o = operand_i;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (shamt_i != 5'd0) begin
            busy_o = 1'b1;
            if (!stall_i) begin
              state_d = SHIFT;
              acc_d   = shift_one(operand_i, dir_i, arith_i);
              cnt_d   = shamt_i - 5'd1;
              dir_d   = dir_i;
              arith_d = arith_i;
            end
          end else begin
            done_o = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt_q != 5'd0) begin
          busy_o = 1'b1;
          if (!stall_i) begin
            acc_d = shift_one(acc_q, dir_q, arith_q);
            cnt_d = cnt_q - 5'd1;
          end
        end else begin
          // Completion cycle: result is acc; leave only once the downstream hold drops.
          done_o   = 1'b1;
          result_o = acc_q;
          if (!stall_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q <= IDLE;
      acc_q   <= ZeroWord;
      cnt_q   <= 5'd0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  assign state_o = state_q;

`endif

endmodule

// File: rtl/ex_iter.sv
// ex_iter: RV32I execute stage. ARI/LOG datapath, shift dispatch to ex_shifter, forwarding
// triple and the EX/MEM output register. EX_BARREL_SHIFT_EN selects the single-cycle shifter.
module ex_iter
  import ex_iter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  ex_iter_if.slave   bus
);

  logic              sh_start, sh_dir, sh_arith, sh_busy, sh_done, sh_state;
  logic [RegBus-1:0] sh_result;
  logic [RegBus-1:0] alu_res;
  logic              alu_valid;
  logic              stallreq;

  logic                  wreg_q, wreg_d;
  logic [RegAddrBus-1:0] wd_q, wd_d;
  logic [RegBus-1:0]     wdata_q, wdata_d;

  always_comb begin
    alu_res   = ZeroWord;
    alu_valid = 1'b0;
    sh_start  = 1'b0;
    sh_dir    = 1'b0;
    sh_arith  = 1'b0;
    case (bus.alusel_i)
      ALU_ARI: begin
        case (bus.func3_i)
          FUNCT3_ADD_SUB: begin
            alu_valid = 1'b1;
            if (bus.opcode_i == OP_OP && bus.func7_i == FUNCT7_ALT)
              alu_res = bus.reg1_i - bus.reg2_i;
            else
              alu_res = bus.reg1_i + bus.reg2_i;
          end
          FUNCT3_SLT: begin
            alu_valid = 1'b1;
            alu_res   = {31'd0, $signed(bus.reg1_i) < $signed(bus.reg2_i)};
          end
          FUNCT3_SLTU: begin
            alu_valid = 1'b1;
            alu_res   = {31'd0, bus.reg1_i < bus.reg2_i};
          end
          default: ;
        endcase
      end
      ALU_LOG: begin
        case (bus.func3_i)
          FUNCT3_XOR: begin alu_valid = 1'b1; alu_res = bus.reg1_i ^ bus.reg2_i; end
          FUNCT3_OR:  begin alu_valid = 1'b1; alu_res = bus.reg1_i | bus.reg2_i; end
          FUNCT3_AND: begin alu_valid = 1'b1; alu_res = bus.reg1_i & bus.reg2_i; end
          default: ;
        endcase
      end
      ALU_SHI: begin
        if (bus.func3_i == FUNCT3_SLL && bus.func7_i == FUNCT7_ZERO) begin
          sh_start = 1'b1;
        end else if (bus.func3_i == FUNCT3_SRL_SRA && bus.func7_i == FUNCT7_ZERO) begin
          sh_start = 1'b1;
          sh_dir   = 1'b1;
        end else if (bus.func3_i == FUNCT3_SRL_SRA && bus.func7_i == FUNCT7_ALT) begin
          sh_start = 1'b1;
          sh_dir   = 1'b1;
          sh_arith = 1'b1;
        end
      end
      default: ;
    endcase
    // Shifts report a result only in their completion cycle.
    if (sh_start) begin
      alu_valid = sh_done;
      alu_res   = sh_done ? sh_result : ZeroWord;
    end
  end

  ex_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (bus.stall_i),
    .start_i   (sh_start),
    .dir_i     (sh_dir),
    .arith_i   (sh_arith),
    .shamt_i   (bus.reg2_i[4:0]),
    .operand_i (bus.reg1_i),
    .busy_o    (sh_busy),
    .done_o    (sh_done),
    .result_o  (sh_result),
    .state_o   (sh_state)
  );

  assign stallreq              = sh_busy;
  assign bus.stallreq_o        = stallreq;
  assign bus.ex_wreg_o         = bus.wreg_i & alu_valid & ~stallreq;
  assign bus.ex_wd_o           = bus.wd_i;
  assign bus.ex_wdata_o        = alu_res;
  assign bus.dbg_shift_state_o = sh_state;

  always_comb begin
    wreg_d  = wreg_q;
    wd_d    = wd_q;
    wdata_d = wdata_q;
    if (!bus.stall_i) begin
      if (stallreq) begin
        wreg_d  = WriteDisable;
        wd_d    = '0;
        wdata_d = ZeroWord;
      end else begin
        wreg_d  = bus.ex_wreg_o;
        wd_d    = bus.ex_wd_o;
        wdata_d = bus.ex_wdata_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wreg_q  <= WriteDisable;
      wd_q    <= '0;
      wdata_q <= ZeroWord;
    end else begin
      wreg_q  <= wreg_d;
      wd_q    <= wd_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.wreg_o  = wreg_q;
  assign bus.wd_o    = wd_q;
  assign bus.wdata_o = wdata_q;

endmodule
